// File: rtl/c17_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c17_bist_pkg
// Brief    : Shared types and constants for the c17 BIST sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package c17_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        APPLY   = 3'd2,
        CAPTURE = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } bist_state_e;

    localparam int unsigned LFSR_W     = 5;
    localparam int unsigned MISR_W     = 16;
    localparam logic [15:0] MISR_POLY  = 16'h1021;
    // x^5 + x^3 + 1 feedback taps
    localparam int unsigned LFSR_TAP_A = 4;
    localparam int unsigned LFSR_TAP_B = 2;

endpackage : c17_bist_pkg
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
// Module   : bist_misr
// Brief    : 16-bit multiple-input signature register absorbing 2 CUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module bist_misr
    import c17_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [1:0]        din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_next;

    assign w_next = {r_sig[MISR_W-2:0], 1'b0}
                  ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
                  ^ {{(MISR_W-2){1'b0}}, din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (clear) begin
            r_sig <= '0;
        end else if (enable) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule : bist_misr
`default_nettype wire

// File: rtl/c17_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : c17_bist_ctrl
// Brief    : LFSR/MISR BIST sequencer for the c17 benchmark block.
//            Optional all-zero extra vector: define BIST_ZERO_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int          NUM_PATTERNS  = 31,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [4:0]  LFSR_SEED     = 5'b00001,
    parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [LFSR_W-1:0] cut_in,
    input  logic [1:0]        cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [4:0]        pat_idx
);

    localparam logic [2:0] ST_IDLE    = 3'(IDLE);
    localparam logic [2:0] ST_SEED    = 3'(SEED);
    localparam logic [2:0] ST_APPLY   = 3'(APPLY);
    localparam logic [2:0] ST_CAPTURE = 3'(CAPTURE);
    localparam logic [2:0] ST_COMPARE = 3'(COMPARE);
    localparam logic [2:0] ST_DONE    = 3'(DONE);

    logic [2:0]        r_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] r_cut_in;
    logic              r_pass;
    logic [4:0]        r_pat_idx;
    logic [3:0]        r_settle;
`ifdef BIST_ZERO_PATTERN_EN
    logic              r_zero;
`endif

    logic [LFSR_W-1:0] w_lfsr_next;
    logic              w_busy;
    logic              w_last_lfsr;
    logic              w_settle_done;
    logic [MISR_W-1:0] w_sig;

    assign w_lfsr_next   = {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
    assign w_busy        = (r_state == ST_SEED)    || (r_state == ST_APPLY) ||
                           (r_state == ST_CAPTURE) || (r_state == ST_COMPARE);
    assign w_last_lfsr   = (r_pat_idx == 5'(NUM_PATTERNS - 1));
    assign w_settle_done = (r_settle == 4'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= '0;
            r_cut_in  <= '0;
            r_pass    <= 1'b0;
            r_pat_idx <= '0;
            r_settle  <= '0;
`ifdef BIST_ZERO_PATTERN_EN
            r_zero    <= 1'b0;
`endif
        end else if (abort && w_busy) begin
            r_state  <= ST_IDLE;
            r_cut_in <= '0;
            r_pass   <= 1'b0;
            r_settle <= '0;
`ifdef BIST_ZERO_PATTERN_EN
            r_zero   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    r_lfsr    <= LFSR_SEED;
                    r_cut_in  <= LFSR_SEED;
                    r_pat_idx <= '0;
                    r_pass    <= 1'b0;
                    r_settle  <= '0;
                    r_state   <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (w_settle_done) begin
                        r_settle <= '0;
                        r_state  <= ST_CAPTURE;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_lfsr <= w_lfsr_next;
`ifdef BIST_ZERO_PATTERN_EN
                    // pat_idx stays at NUM_PATTERNS after the zero vector so it cannot wrap
                    if (r_zero) begin
                        r_zero   <= 1'b0;
                        r_cut_in <= '0;
                        r_state  <= ST_COMPARE;
                    end else if (w_last_lfsr) begin
                        r_zero    <= 1'b1;
                        r_cut_in  <= '0;
                        r_pat_idx <= r_pat_idx + 5'd1;
                        r_state   <= ST_APPLY;
                    end else begin
`else
                    if (w_last_lfsr) begin
                        r_cut_in  <= '0;
                        r_pat_idx <= r_pat_idx + 5'd1;
                        r_state   <= ST_COMPARE;
                    end else begin
`endif
                        r_cut_in  <= w_lfsr_next;
                        r_pat_idx <= r_pat_idx + 5'd1;
                        r_state   <= ST_APPLY;
                    end
                end
                ST_COMPARE: begin
                    r_pass  <= (w_sig == GOLDEN_SIG);
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Abort suppresses both the clear and the capture in its cycle
    bist_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .clear  ((r_state == ST_SEED) && !abort),
        .enable ((r_state == ST_CAPTURE) && !abort),
        .din    (cut_out),
        .sig    (w_sig)
    );

    assign cut_in    = r_cut_in;
    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign signature = w_sig;
    assign pat_idx   = r_pat_idx;

endmodule : c17_bist_ctrl
`default_nettype wire

// File: tb/tb_c17_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_c17_bist_ctrl
// Brief    : Self-checking bench for c17_bist_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c17_bist_ctrl;

    localparam int NP = 31;
    localparam int SC = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, abort_a, start_b;
    logic [1:0]  cut_out_a, cut_out_b;
    logic [4:0]  cut_in_a, cut_in_b, cut_in_c;
    logic [4:0]  pat_idx_a, pat_idx_b, pat_idx_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [15:0] sig_a, sig_b, sig_c;
    logic [1:0]  tt [32];

    assign cut_out_a = tt[cut_in_a];

    c17_bist_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .cut_in(cut_in_a), .cut_out(cut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a), .pat_idx(pat_idx_a)
    );

    c17_bist_ctrl #(.NUM_PATTERNS(2), .SETTLE_CYCLES(1), .GOLDEN_SIG(16'h0003)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
        .cut_in(cut_in_b), .cut_out(cut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b), .pat_idx(pat_idx_b)
    );

    c17_bist_ctrl #(.NUM_PATTERNS(2), .SETTLE_CYCLES(1), .GOLDEN_SIG(16'h0002)) dut_c (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
        .cut_in(cut_in_c), .cut_out(cut_out_b), .busy(busy_c), .done(done_c),
        .pass(pass_c), .signature(sig_c), .pat_idx(pat_idx_c)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_vec [33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lfsr_step(input int q);
        return ((q << 1) & 31) | (((q >> 4) ^ (q >> 2)) & 1);
    endfunction

    function automatic int misr_step(input int s, input int d);
        int t;
        t = (s << 1) & 32'hFFFF;
        if ((s & 32'h8000) != 0) t = t ^ 32'h1021;
        return t ^ d;
    endfunction

    function automatic logic [1:0] c17(input logic [4:0] g);
        logic n10, n11, n16, n19;
        n10 = ~(g[0] & g[2]);
        n11 = ~(g[2] & g[3]);
        n16 = ~(g[1] & n11);
        n19 = ~(n11 & g[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    // Reference: vector list and final signature from the LFSR/MISR rules
    task automatic build_model(output int sig, output int nvec);
        int q;
        q = 1; sig = 0;
        for (int i = 0; i < NP; i++) begin
            exp_vec[i] = q;
            sig = misr_step(sig, int'(tt[q]));
            q = lfsr_step(q);
        end
        nvec = NP;
`ifdef BIST_ZERO_PATTERN_EN
        exp_vec[NP] = 0;
        sig = misr_step(sig, int'(tt[0]));
        nvec = NP + 1;
`endif
    endtask

    task automatic do_run(input string tag, input bit abort_in_done);
        int esig, nvec, lat, e;
        bit epass;
        build_model(esig, nvec);
        epass = (esig == 0);
        lat = nvec * (SC + 1) + 3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        e = 1;
        while (!done_a && e < 400) begin
            if (busy_a && cut_in_a != 5'd0)
                check({tag, " cut_in"}, 32'(cut_in_a), 32'(exp_vec[pat_idx_a]));
            tick();
            e++;
        end
        check({tag, " done edge"}, 32'(e), 32'(lat));
        check({tag, " signature"}, 32'(sig_a), 32'(esig));
        check({tag, " pass"}, 32'(pass_a), 32'(epass));
        check({tag, " final pat_idx"}, 32'(pat_idx_a), 32'(NP));
        if (abort_in_done) abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check({tag, " done pulse width"}, 32'(done_a), 32'(0));
        check({tag, " pass held in idle"}, 32'(pass_a), 32'(epass));
        check({tag, " cut_in idle"}, 32'(cut_in_a), 32'(0));
    endtask

    typedef struct {
        logic [1:0]  co;
        logic [15:0] sig1;
        logic [15:0] sig2;
        logic        pass_b;
        logic        pass_c;
    } short_vec_t;

    initial begin
        short_vec_t tbl [4];
        int q_done [$];
        int e, seen;

        tbl[0] = '{2'b01, 16'h0001, 16'h0003, 1'b1, 1'b0};
        tbl[1] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 16'h0002, 16'h0006, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 16'h0003, 16'h0005, 1'b0, 1'b0};

        rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; cut_out_b = 2'b00;
        for (int i = 0; i < 32; i++) tt[i] = 2'b00;
        repeat (2) tick();
        check("reset cut_in", 32'(cut_in_a), 32'(0));
        check("reset busy", 32'(busy_a), 32'(0));
        check("reset done", 32'(done_a), 32'(0));
        check("reset pass", 32'(pass_a), 32'(0));
        check("reset signature", 32'(sig_a), 32'(0));
        check("reset pat_idx", 32'(pat_idx_a), 32'(0));
        rst = 1'b0;
        tick();

        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort in idle busy", 32'(busy_a), 32'(0));

        // Two-vector instances: signature after each capture, done at edge 7
        for (int r = 0; r < 4; r++) begin
            cut_out_b = tbl[r].co;
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            repeat (3) tick();
            check($sformatf("short[%0d] sig1", r), 32'(sig_b), 32'(tbl[r].sig1));
            repeat (2) tick();
            check($sformatf("short[%0d] sig2", r), 32'(sig_c), 32'(tbl[r].sig2));
            check($sformatf("short[%0d] done early", r), 32'(done_b), 32'(0));
            tick();
            check($sformatf("short[%0d] done edge7", r), 32'({done_b, done_c}), 32'(2'b11));
            check($sformatf("short[%0d] pass_b", r), 32'(pass_b), 32'(tbl[r].pass_b));
            check($sformatf("short[%0d] pass_c", r), 32'(pass_c), 32'(tbl[r].pass_c));
            tick();
            check($sformatf("short[%0d] done cleared", r), 32'(done_b), 32'(0));
            check($sformatf("short[%0d] pass held", r), 32'(pass_b), 32'(tbl[r].pass_b));
        end

        do_run("zero-cut", 1'b1);

        for (int i = 0; i < 32; i++) tt[i] = c17(5'(i));
        do_run("c17", 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) tt[i] = 2'($urandom_range(0, 3));
            do_run($sformatf("rand%0d", r), 1'b0);
        end

        // Abort during the third APPLY, then a clean rerun
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        e = 0;
        while (!(pat_idx_a == 5'd2 && cut_in_a != 5'd0) && e < 50) begin
            tick();
            e++;
        end
        check("reach third apply", 32'(e < 50), 32'(1));
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort busy", 32'(busy_a), 32'(0));
        check("abort pass", 32'(pass_a), 32'(0));
        check("abort cut_in", 32'(cut_in_a), 32'(0));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_a) seen++;
            tick();
        end
        check("abort no done", 32'(seen), 32'(0));
        do_run("after abort", 1'b0);

        // start held high: done pulses exactly at lat and 2*lat+1
        start_a = 1'b1;
        tick();
        for (e = 1; e < 170; e++) begin
            if (done_a) q_done.push_back(e);
            if (e == 100) start_a = 1'b0;
            tick();
        end
        check("held start pulses", 32'(q_done.size()), 32'(2));
        if (q_done.size() == 2) begin
`ifdef BIST_ZERO_PATTERN_EN
            check("held start first", 32'(q_done[0]), 32'(67));
            check("held start second", 32'(q_done[1]), 32'(135));
`else
            check("held start first", 32'(q_done[0]), 32'(65));
            check("held start second", 32'(q_done[1]), 32'(131));
`endif
        end

        // Asynchronous reset mid-APPLY
        for (int i = 0; i < 32; i++) tt[i] = 2'b11;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrun rst busy", 32'(busy_a), 32'(0));
        check("midrun rst cut_in", 32'(cut_in_a), 32'(0));
        check("midrun rst sig", 32'({sig_a, pat_idx_a, done_a, pass_a}), 32'(0));
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_a || busy_a) seen++;
            tick();
        end
        check("post rst idle", 32'(seen), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_c17_bist_ctrl
`default_nettype wire
